// File: rtl/mem_bridge.sv
// Multicycle bridge between the RV32I control/datapath and the physical memory port.
// Latches one load/store, runs a single bounded-wait bus transaction and returns a one-cycle completion pulse.
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic [31:0] cpu_rdata,
  output logic        cpu_resp,
  output logic        cpu_err,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_waitCnt;

  logic [1:0]  w_size;
  logic [1:0]  w_lane;
  logic [3:0]  w_byteEn;
  logic        w_reqValid;
  logic        w_reqErr;
  logic        w_unused;

  // funct3[2] only picks sign/zero extension, which the regfile mux handles.
  assign w_unused   = cpu_funct3[2];
  assign w_size     = cpu_funct3[1:0];
  assign w_lane     = cpu_address[1:0];
  assign w_reqValid = cpu_read | cpu_write;

  always_comb begin
    w_byteEn = 4'b1111;
    w_reqErr = 1'b0;
    case (w_size)
      2'b00: w_byteEn = 4'b0001 << w_lane;
      2'b01: begin
        w_byteEn = 4'b0011 << w_lane;
        w_reqErr = w_lane[0];
      end
      2'b10: w_reqErr = (w_lane != 2'b00);
      default: w_reqErr = 1'b1;
    endcase
    if (cpu_read && cpu_write) begin
      w_reqErr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_waitCnt        <= 16'd0;
      cpu_rdata        <= 32'd0;
      cpu_resp         <= 1'b0;
      cpu_err          <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= 32'd0;
      pmem_wdata       <= 32'd0;
      pmem_byte_enable <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_reqValid) begin
            pmem_address     <= {cpu_address[31:2], 2'b00};
            pmem_wdata       <= cpu_wdata;
            pmem_byte_enable <= cpu_read ? 4'b1111 : w_byteEn;
            r_waitCnt        <= 16'd0;
            // Rejected requests never touch the bus; they complete straight away.
            if (w_reqErr) begin
              cpu_resp <= 1'b1;
              cpu_err  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              pmem_read  <= cpu_read;
              pmem_write <= ~cpu_read;
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (pmem_resp) begin
            if (pmem_read) begin
              cpu_rdata <= pmem_rdata;
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            cpu_resp   <= 1'b1;
            cpu_err    <= 1'b0;
            r_state    <= S_DONE;
          end else if (r_waitCnt == LP_LAST_WAIT) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            cpu_resp   <= 1'b1;
            cpu_err    <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        S_DONE: begin
          cpu_resp <= 1'b0;
          cpu_err  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge, built with an 8-cycle timeout
// so that the expiry boundary can be reached in a few cycles.
module tb_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_resp;
  logic        cpu_err;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int checkCount = 0;
  int errorCount = 0;

  mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_address      (cpu_address),
    .cpu_wdata        (cpu_wdata),
    .cpu_funct3       (cpu_funct3),
    .cpu_rdata        (cpu_rdata),
    .cpu_resp         (cpu_resp),
    .cpu_err          (cpu_err),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3);
    cpu_read    = rd;
    cpu_write   = wr;
    cpu_address = addr;
    cpu_wdata   = wdata;
    cpu_funct3  = f3;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_resp"},  32'(cpu_resp), 32'd0);
    checkOutput({tag, "_err"},   32'(cpu_err), 32'd0);
    checkOutput({tag, "_rdata"}, cpu_rdata, 32'd0);
    checkOutput({tag, "_rd"},    32'(pmem_read), 32'd0);
    checkOutput({tag, "_wr"},    32'(pmem_write), 32'd0);
    checkOutput({tag, "_addr"},  pmem_address, 32'd0);
    checkOutput({tag, "_wdata"}, pmem_wdata, 32'd0);
    checkOutput({tag, "_be"},    32'(pmem_byte_enable), 32'd0);
  endtask

  // One request held until cpu_resp; the bus answers after 'waits' wait states (-1 = never).
  // Latency counts edges from the request being driven to cpu_resp being visible.
  task automatic runAccess(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                           input int waits, input logic [31:0] busData,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input int expReadCyc, input int expWriteCyc,
                           input int expLatency, input logic expErr, input logic [31:0] expRdata);
    int readCyc  = 0;
    int writeCyc = 0;
    int latency  = 0;
    logic seen   = 1'b0;
    logic errSeen = 1'b0;
    logic [31:0] rdSeen = 32'd0;
    applyStimulus(rd, wr, addr, wdata, f3);
    pmem_rdata = busData;
    pmem_resp  = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      stepCycle();
      if (pmem_read) readCyc++;
      if (pmem_write) writeCyc++;
      if ((pmem_read || pmem_write) && (readCyc + writeCyc == 1)) begin
        checkOutput({tag, "_addr"}, pmem_address, expAddr);
        checkOutput({tag, "_be"}, 32'(pmem_byte_enable), 32'(expBe));
        if (wr) checkOutput({tag, "_wdata"}, pmem_wdata, wdata);
      end
      pmem_resp = (waits >= 0) && (pmem_read || pmem_write) && (readCyc + writeCyc == waits + 1);
      if (cpu_resp) begin
        seen    = 1'b1;
        latency = i;
        errSeen = cpu_err;
        rdSeen  = cpu_rdata;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      end
    end
    pmem_resp = 1'b0;
    checkOutput({tag, "_respSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(latency), 32'(expLatency));
    checkOutput({tag, "_readCycles"}, 32'(readCyc), 32'(expReadCyc));
    checkOutput({tag, "_writeCycles"}, 32'(writeCyc), 32'(expWriteCyc));
    checkOutput({tag, "_err"}, 32'(errSeen), 32'(expErr));
    checkOutput({tag, "_rdata"}, rdSeen, expRdata);
    stepCycle();
    checkOutput({tag, "_pulseEnd"}, 32'(cpu_resp), 32'd0);
  endtask

  initial begin
    int rises;
    int respCycles;
    int lowRun;
    int minGap;
    logic prevStrobe;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    pmem_rdata = 32'd0;
    pmem_resp  = 1'b0;
    stepCycle();
    stepCycle();
    checkAllZero("reset");
    rst_n = 1'b1;
    stepCycle();

    // Zero-wait word load.
    runAccess("lw", 1, 0, 32'h0000_1004, 32'd0, 3'b010, 0, 32'hDEAD_BEEF,
              32'h0000_1004, 4'b1111, 1, 0, 2, 0, 32'hDEAD_BEEF);
    // Byte and halfword stores with three wait states; read data must stay.
    runAccess("sb", 0, 1, 32'h0000_2003, 32'hAB00_0000, 3'b000, 3, 32'h5555_5555,
              32'h0000_2000, 4'b1000, 0, 4, 5, 0, 32'hDEAD_BEEF);
    runAccess("sh", 0, 1, 32'h0000_2002, 32'hCDEF_0000, 3'b001, 3, 32'h5555_5555,
              32'h0000_2000, 4'b1100, 0, 4, 5, 0, 32'hDEAD_BEEF);
    // Rejected accesses complete one cycle later with no strobe.
    runAccess("swMis", 0, 1, 32'h0000_2002, 32'h1, 3'b010, 0, 32'h0,
              32'h0, 4'b0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    runAccess("lhMis", 1, 0, 32'h0000_2001, 32'h0, 3'b001, 0, 32'h0,
              32'h0, 4'b0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    runAccess("rdWr", 1, 1, 32'h0000_2000, 32'h0, 3'b010, 0, 32'h0,
              32'h0, 4'b0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    runAccess("size11", 1, 0, 32'h0000_2000, 32'h0, 3'b011, 0, 32'h0,
              32'h0, 4'b0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    // Timeout after 8 strobe cycles, then a response landing on the last allowed cycle.
    runAccess("tmo", 1, 0, 32'h0000_4000, 32'h0, 3'b010, -1, 32'h1111_1111,
              32'h0000_4000, 4'b1111, 8, 0, 9, 1, 32'hDEAD_BEEF);
    runAccess("lastWait", 1, 0, 32'h0000_4008, 32'h0, 3'b010, 7, 32'hCAFE_F00D,
              32'h0000_4008, 4'b1111, 8, 0, 9, 0, 32'hCAFE_F00D);

    // Reset during the second ACCESS cycle of a read.
    applyStimulus(1'b1, 1'b0, 32'h0000_3000, 32'd0, 3'b010);
    stepCycle();
    stepCycle();
    checkOutput("midRst_strobeBefore", 32'(pmem_read), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    stepCycle();
    checkAllZero("midRst");
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    stepCycle();
    pmem_resp = 1'b0;
    checkOutput("lateResp_resp1", 32'(cpu_resp), 32'd0);
    stepCycle();
    checkOutput("lateResp_resp2", 32'(cpu_resp), 32'd0);
    checkOutput("lateResp_rd", 32'(pmem_read), 32'd0);
    // Byte load: address is word-aligned and enables read as all ones.
    runAccess("lbAfterRst", 1, 0, 32'h0000_5001, 32'h0, 3'b000, 0, 32'h1234_5678,
              32'h0000_5000, 4'b1111, 1, 0, 2, 0, 32'h1234_5678);

    // Back-to-back loads with cpu_read held until the second completion.
    applyStimulus(1'b1, 1'b0, 32'h0000_6000, 32'd0, 3'b010);
    pmem_rdata = 32'hA5A5_0001;
    rises = 0;
    respCycles = 0;
    lowRun = 0;
    minGap = 999;
    prevStrobe = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      if (pmem_read && !prevStrobe) begin
        rises++;
        if (rises > 1 && lowRun < minGap) minGap = lowRun;
      end
      if (pmem_read) lowRun = 0;
      else lowRun++;
      if (cpu_resp) begin
        respCycles++;
        if (respCycles == 2) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      end
      pmem_resp  = pmem_read;
      prevStrobe = pmem_read;
    end
    pmem_resp = 1'b0;
    checkOutput("b2b_strobes", 32'(rises), 32'd2);
    checkOutput("b2b_respCycles", 32'(respCycles), 32'd2);
    checkOutput("b2b_gap", 32'(minGap), 32'd2);
    checkOutput("b2b_rdata", cpu_rdata, 32'hA5A5_0001);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
